// File: rtl/i2c_trigger_match.sv
// ============================================================================
// Module      : i2c_trigger_match
// Description : Matches the leading bytes of an I2C transaction against an
//               armed pattern, then emits one delayed trigger pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_trigger_match #(
    parameter int I2C_WIDTH   = 9,
    parameter int MATCH_LEN   = 4,
    parameter int DELAY_WIDTH = 16,
    parameter int PULSE_WIDTH = 8
) (
    input  logic                   sysclk,
    input  logic                   rst,
    input  logic [I2C_WIDTH-1:0]   byte_in,
    input  logic                   byte_ready,
    input  logic                   sop,
    input  logic                   eot,
    input  logic                   arm,
    input  logic                   disarm,
    input  logic [8*MATCH_LEN-1:0] pattern,
    input  logic [2:0]             pattern_len,
    input  logic                   require_ack,
    input  logic [DELAY_WIDTH-1:0] delay,
    input  logic [PULSE_WIDTH-1:0] pulse_len,
    output logic                   armed,
    output logic                   trigger,
    output logic                   done,
    output logic [2:0]             byte_index,
    output logic [7:0]             fire_count
);

    localparam int       C_CW      = (DELAY_WIDTH > PULSE_WIDTH) ? DELAY_WIDTH : PULSE_WIDTH;
    localparam logic [2:0] C_MAX_LEN = 3'(MATCH_LEN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_SOP = 3'd1;
    localparam logic [2:0] S_COMPARE  = 3'd2;
    localparam logic [2:0] S_DELAY    = 3'd3;
    localparam logic [2:0] S_FIRE     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [C_CW-1:0]        cnt_q, cnt_d;
    logic [8*MATCH_LEN-1:0] pat_q;
    logic [2:0]             len_q;
    logic                   ack_q;
    logic [DELAY_WIDTH-1:0] delay_q;
    logic [PULSE_WIDTH-1:0] pulse_q;
    logic                   armed_q, trigger_q, done_q;
    logic [7:0]             fire_count_q;

    logic                   w_arm_ok;
    logic [2:0]             w_len;
    logic [7:0]             w_pat_byte;
    logic                   w_match;
    logic                   w_last;
    logic [PULSE_WIDTH-1:0] w_pulse_m1;

    assign w_arm_ok   = arm && !disarm && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign w_len      = (pattern_len == 3'd0)       ? 3'd1      :
                        (pattern_len > C_MAX_LEN)   ? C_MAX_LEN : pattern_len;
    assign w_pat_byte = pat_q[{idx_q, 3'b000} +: 8];
    assign w_match    = (byte_in[I2C_WIDTH-1:1] == w_pat_byte) && (!ack_q || !byte_in[0]);
    assign w_last     = (idx_q == (len_q - 3'd1));
    // Pulse length 0 still produces a one-cycle pulse.
    assign w_pulse_m1 = (pulse_q == '0) ? '0 : (pulse_q - PULSE_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (disarm) begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) state_d = S_WAIT_SOP;
                end
                S_WAIT_SOP: begin
                    if (sop) begin
                        state_d = S_COMPARE;
                        idx_d   = 3'd0;
                    end
                end
                S_COMPARE: begin
                    // A repeated start restarts the comparison at byte 0.
                    if (sop) begin
                        idx_d = 3'd0;
                    end else if (eot) begin
                        state_d = S_WAIT_SOP;
                        idx_d   = 3'd0;
                    end else if (byte_ready) begin
                        if (w_match && w_last) begin
                            state_d = S_DELAY;
                            cnt_d   = C_CW'(delay_q);
                        end else if (w_match) begin
                            idx_d = idx_q + 3'd1;
                        end else begin
                            state_d = S_WAIT_SOP;
                            idx_d   = 3'd0;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = S_FIRE;
                        cnt_d   = C_CW'(w_pulse_m1);
                    end else begin
                        cnt_d = cnt_q - C_CW'(1);
                    end
                end
                S_FIRE: begin
                    if (cnt_q == '0) state_d = S_DONE;
                    else             cnt_d   = cnt_q - C_CW'(1);
                end
                S_DONE: begin
                    if (arm) state_d = S_WAIT_SOP;
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            pat_q        <= '0;
            len_q        <= 3'd1;
            ack_q        <= 1'b0;
            delay_q      <= '0;
            pulse_q      <= '0;
            armed_q      <= 1'b0;
            trigger_q    <= 1'b0;
            done_q       <= 1'b0;
            fire_count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (w_arm_ok) begin
                pat_q   <= pattern;
                len_q   <= w_len;
                ack_q   <= require_ack;
                delay_q <= delay;
                pulse_q <= pulse_len;
            end
            armed_q   <= (state_d == S_WAIT_SOP) || (state_d == S_COMPARE) || (state_d == S_DELAY);
            // Trigger follows FIRE by one edge so it starts two edges after the last byte.
            trigger_q <= (state_q == S_FIRE) && !disarm;
            done_q    <= (state_q == S_DONE) && !disarm && !w_arm_ok;
            if (!disarm && (state_q == S_FIRE) && (cnt_q == '0) && (fire_count_q != 8'hFF))
                fire_count_q <= fire_count_q + 8'd1;
        end
    end

    assign armed      = armed_q;
    assign trigger    = trigger_q;
    assign done       = done_q;
    assign byte_index = idx_q;
    assign fire_count = fire_count_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_trigger_match.sv
// ============================================================================
// Module      : tb_i2c_trigger_match
// Description : Self-checking bench for i2c_trigger_match.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_trigger_match;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  byte_in = '0;
    logic        byte_ready = 1'b0, sop = 1'b0, eot = 1'b0;
    logic        arm = 1'b0, disarm = 1'b0;
    logic [31:0] pattern = '0;
    logic [2:0]  pattern_len = 3'd1;
    logic        require_ack = 1'b0;
    logic [15:0] delay = '0;
    logic [7:0]  pulse_len = '0;
    logic        armed, trigger, done;
    logic [2:0]  byte_index;
    logic [7:0]  fire_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int hi_cnt = 0;
    logic trig_prev = 1'b0;
    int exp_fc = 0;
    int t_last = 0;

    i2c_trigger_match dut (
        .sysclk(sysclk), .rst(rst), .byte_in(byte_in), .byte_ready(byte_ready),
        .sop(sop), .eot(eot), .arm(arm), .disarm(disarm), .pattern(pattern),
        .pattern_len(pattern_len), .require_ack(require_ack), .delay(delay),
        .pulse_len(pulse_len), .armed(armed), .trigger(trigger), .done(done),
        .byte_index(byte_index), .fire_count(fire_count)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (trigger === 1'b1) begin
            hi_cnt = hi_cnt + 1;
            if (trig_prev !== 1'b1) rise_cyc = cyc;
        end
        trig_prev = trigger;
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic clr_mon();
        rise_cyc = -1;
        hi_cnt   = 0;
    endtask

    task automatic do_arm(input logic [31:0] pat, input logic [2:0] len, input logic ack,
                          input logic [15:0] dly, input logic [7:0] pl);
        pattern = pat; pattern_len = len; require_ack = ack; delay = dly; pulse_len = pl;
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic do_disarm();
        disarm = 1'b1; step(); disarm = 1'b0;
    endtask

    task automatic send_sop();
        sop = 1'b1; step(); sop = 1'b0;
    endtask

    task automatic send_eot();
        eot = 1'b1; step(); eot = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic a);
        byte_in = {d, a}; byte_ready = 1'b1; step(); byte_ready = 1'b0;
        t_last = cyc;
    endtask

    task automatic check_fire(input string name, input int exp_rise, input int exp_hi);
        checks++;
        if (rise_cyc !== exp_rise) begin
            errors++;
            $display("FAIL %s rise: got cycle %0d expected %0d", name, rise_cyc, exp_rise);
        end
        checks++;
        if (hi_cnt !== exp_hi) begin
            errors++;
            $display("FAIL %s width: got %0d expected %0d", name, hi_cnt, exp_hi);
        end
    endtask

    task automatic check_none(input string name);
        checks++;
        if (hi_cnt !== 0) begin
            errors++;
            $display("FAIL %s no-trigger: got %0d high cycles expected 0", name, hi_cnt);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check_bit({name, " armed"}, armed, 1'b0);
        check_bit({name, " trigger"}, trigger, 1'b0);
        check_bit({name, " done"}, done, 1'b0);
        checks++;
        if (byte_index !== 3'd0 || fire_count !== 8'd0) begin
            errors++;
            $display("FAIL %s idx/count: got %0d/%0d expected 0/0", name, byte_index, fire_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; step(3); rst = 1'b0; exp_fc = 0;
        check_idle_outputs("reset");
    endtask

    task automatic test_basic();
        clr_mon();
        do_arm(32'h0000_00A0, 3'd1, 1'b1, 16'd0, 8'd3);
        check_bit("basic armed", armed, 1'b1);
        send_sop();
        send_byte(8'hA0, 1'b0);
        step(10);
        exp_fc++;
        check_fire("basic", t_last + 2, 3);
        check_bit("basic done", done, 1'b1);
        check_bit("basic armed after", armed, 1'b0);
        checks++;
        if (fire_count !== 8'(exp_fc)) begin
            errors++;
            $display("FAIL basic fire_count: got %0d expected %0d", fire_count, exp_fc);
        end
    endtask

    task automatic test_multibyte();
        clr_mon();
        do_arm(32'h0000_10A0, 3'd2, 1'b1, 16'd5, 8'd2);
        send_sop();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h11, 1'b0);
        step(12);
        check_none("multi mismatch");
        check_bit("multi still armed", armed, 1'b1);
        checks++;
        if (byte_index !== 3'd0) begin
            errors++;
            $display("FAIL multi idx: got %0d expected 0", byte_index);
        end
        send_sop();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h10, 1'b0);
        step(12);
        exp_fc++;
        check_fire("multi match", t_last + 7, 2);
    endtask

    task automatic test_ack();
        clr_mon();
        do_arm(32'h0000_00A0, 3'd1, 1'b1, 16'd1, 8'd1);
        send_sop();
        send_byte(8'hA0, 1'b1);
        step(8);
        check_none("ack nak");
        check_bit("ack nak armed", armed, 1'b1);
        do_disarm();
        clr_mon();
        do_arm(32'h0000_00A0, 3'd1, 1'b0, 16'd1, 8'd1);
        send_sop();
        send_byte(8'hA0, 1'b1);
        step(8);
        exp_fc++;
        check_fire("ack ignored", t_last + 3, 1);
    endtask

    task automatic test_restart();
        clr_mon();
        do_arm(32'h0000_10A0, 3'd2, 1'b0, 16'd2, 8'd2);
        send_sop();
        send_byte(8'hA0, 1'b0);
        checks++;
        if (byte_index !== 3'd1) begin
            errors++;
            $display("FAIL restart idx1: got %0d expected 1", byte_index);
        end
        send_sop();
        checks++;
        if (byte_index !== 3'd0) begin
            errors++;
            $display("FAIL restart idx0: got %0d expected 0", byte_index);
        end
        send_byte(8'hA0, 1'b0);
        send_byte(8'h10, 1'b0);
        step(10);
        exp_fc++;
        check_fire("restart", t_last + 4, 2);
        do_disarm();
        clr_mon();
        do_arm(32'h0000_10A0, 3'd2, 1'b0, 16'd2, 8'd2);
        send_sop();
        send_byte(8'hA0, 1'b0);
        send_eot();
        send_byte(8'h10, 1'b0);
        step(10);
        check_none("eot mid-pattern");
    endtask

    task automatic test_shadow();
        do_disarm();
        clr_mon();
        do_arm(32'h0000_00A0, 3'd1, 1'b0, 16'd5, 8'd2);
        delay = 16'd100; pulse_len = 8'd9; pattern = 32'h0000_0055;
        send_sop();
        send_byte(8'hA0, 1'b0);
        step(15);
        exp_fc++;
        check_fire("shadow", t_last + 7, 2);
        clr_mon();
        send_sop();
        send_byte(8'hA0, 1'b0);
        step(15);
        check_none("one-shot");
        check_bit("one-shot done", done, 1'b1);
        clr_mon();
        do_arm(32'h0000_00A0, 3'd1, 1'b0, 16'd0, 8'd1);
        check_bit("rearm clears done", done, 1'b0);
        send_sop();
        send_byte(8'hA0, 1'b0);
        step(6);
        exp_fc++;
        check_fire("rearm", t_last + 2, 1);
        checks++;
        if (fire_count !== 8'(exp_fc)) begin
            errors++;
            $display("FAIL rearm fire_count: got %0d expected %0d", fire_count, exp_fc);
        end
    endtask

    task automatic test_abort();
        do_disarm();
        clr_mon();
        do_arm(32'h0000_00A0, 3'd1, 1'b0, 16'd20, 8'd3);
        send_sop();
        send_byte(8'hA0, 1'b0);
        step(3);
        do_disarm();
        check_bit("abort armed", armed, 1'b0);
        step(30);
        check_none("abort");
        clr_mon();
        do_arm(32'h0000_00A0, 3'd1, 1'b0, 16'd0, 8'd10);
        send_sop();
        send_byte(8'hA0, 1'b0);
        for (int i = 0; i < 20 && trigger !== 1'b1; i++) step();
        check_bit("rst-test trigger reached", trigger, 1'b1);
        step(2);
        rst = 1'b1; step(); 
        check_idle_outputs("rst mid-pulse");
        rst = 1'b0; exp_fc = 0;
    endtask

    // Random transactions checked against a byte-level matching model.
    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [31:0] pat;
            logic [2:0]  len;
            int          eff;
            logic        ack;
            int          dly, pl, nb, t_match;
            bit          ok;
            pat = $urandom; len = 3'($urandom_range(0, 7)); ack = 1'($urandom);
            dly = $urandom_range(0, 10); pl = $urandom_range(0, 5);
            eff = (len == 0) ? 1 : ((len > 4) ? 4 : int'(len));
            do_disarm();
            clr_mon();
            do_arm(pat, len, ack, 16'(dly), 8'(pl));
            send_sop();
            ok = 1'b1; t_match = -1;
            nb = eff + $urandom_range(0, 1);
            for (int k = 0; k < nb; k++) begin
                logic [7:0] d;
                logic       a;
                d = (k < 4) ? pat[8*k +: 8] : 8'($urandom);
                if ($urandom_range(0, 7) == 0) d = 8'($urandom);
                a = ($urandom_range(0, 5) == 0);
                send_byte(d, a);
                if (ok && k < eff) begin
                    if (d != pat[8*k +: 8] || (ack && a)) ok = 1'b0;
                    else if (k == eff - 1) t_match = t_last;
                end
            end
            send_eot();
            step(dly + pl + 8);
            if (ok) begin
                exp_fc++;
                check_fire("random", t_match + 2 + dly, (pl == 0) ? 1 : pl);
            end else begin
                check_none("random");
            end
        end
        checks++;
        if (fire_count !== 8'(exp_fc)) begin
            errors++;
            $display("FAIL random fire_count: got %0d expected %0d", fire_count, exp_fc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multibyte();
        test_ack();
        test_restart();
        test_shadow();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
